// File: rtl/dpram_fifo_pkg.sv
// Shared defaults and output-buffer state encoding for the dual-port RAM FIFO.
package dpram_fifo_pkg;

    localparam int unsigned DEF_AW = 4;
    localparam int unsigned DEF_DW = 16;

    // Encoded value equals the number of words held in the output buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } obuf_state_t;

endpackage

// File: rtl/dpram_fifo_obuf.sv
// Two-entry skid buffer that catches RAM read returns and presents the FIFO head.
module dpram_fifo_obuf
    import dpram_fifo_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_v,
    input  logic [DW-1:0] in_d,
    output logic          out_v,
    output logic [DW-1:0] out_d,
    input  logic          out_rdy,
    output logic [1:0]    cnt
);

    obuf_state_t   state_q;
    obuf_state_t   state_d;
    logic [DW-1:0] head_q;
    logic [DW-1:0] skid_q;
    logic          pop;

    assign out_v = (state_q != EMPTY);
    assign out_d = head_q;
    assign cnt   = state_q;
    assign pop   = out_v & out_rdy & ~flush;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: occupancy changes by +in_v -pop; flush empties the buffer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (in_v) state_d = ONE;
            ONE:     if (in_v && !pop) state_d = TWO;
                     else if (!in_v && pop) state_d = EMPTY;
            TWO:     if (pop && !in_v) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    // Data path: a return fills the first free slot after any same-cycle pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            case (state_q)
                EMPTY: if (in_v) head_q <= in_d;
                ONE: begin
                    if (in_v) begin
                        if (pop) head_q <= in_d;
                        else     skid_q <= in_d;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_q <= skid_q;
                        if (in_v) skid_q <= in_d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FWFT FIFO controller: pointers and RAM occupancy, fetch scheduling, RAM port wiring.
module dpram_fifo_ctrl
    import dpram_fifo_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_v,
    input  logic [DW-1:0] wr_d,
    output logic          wr_rdy,
    output logic          rd_v,
    output logic [DW-1:0] rd_d,
    input  logic          rd_rdy,
    output logic [AW+1:0] level,
    output logic          ovf,
    output logic [AW-1:0] ram_a_a,
    output logic [DW-1:0] ram_d_a,
    output logic          ram_w_a,
    output logic [AW-1:0] ram_a_b,
    output logic [DW-1:0] ram_d_b,
    output logic          ram_w_b,
    input  logic [DW-1:0] ram_q_b
);

    localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] ram_cnt;
    logic        inflight;
    logic [1:0]  obuf_cnt;
    logic        full;
    logic        push;
    logic        pop;
    logic        fetch;

    assign full  = (ram_cnt == CAP);
    assign push  = wr_v & ~full & ~flush;
    assign pop   = rd_v & rd_rdy;
    assign ovf   = wr_v & full & ~flush;
    // Count of words already owned by the output path must leave room for the return.
    assign fetch = (ram_cnt != '0) & ~flush
                 & (({1'b0, obuf_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    // Handshake outputs are held inactive while reset is asserted.
    assign wr_rdy  = ~full & rst;
    assign ram_w_a = push & rst;
    assign ram_a_a = wr_ptr[AW-1:0];
    assign ram_d_a = wr_d;
    assign ram_a_b = rd_ptr[AW-1:0];
    assign ram_d_b = '0;
    assign ram_w_b = 1'b0;

    assign level = {1'b0, ram_cnt} + {{(AW+1){1'b0}}, inflight} + {{AW{1'b0}}, obuf_cnt};

    // Pointers, RAM occupancy and the one-cycle read-in-flight flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (fetch) rd_ptr <= rd_ptr + 1'b1;
            ram_cnt  <= ram_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, fetch};
            inflight <= fetch;
        end
    end

    dpram_fifo_obuf #(
        .DW(DW)
    ) u_obuf (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .in_v   (inflight),
        .in_d   (ram_q_b),
        .out_v  (rd_v),
        .out_d  (rd_d),
        .out_rdy(rd_rdy),
        .cnt    (obuf_cnt)
    );

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed self-checking bench for dpram_fifo_ctrl with a registered-read RAM model.
module tb_dpram_fifo_ctrl;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_v = 1'b0;
    logic [DW-1:0] wr_d = '0;
    logic          wr_rdy;
    logic          rd_v;
    logic [DW-1:0] rd_d;
    logic          rd_rdy = 1'b0;
    logic [AW+1:0] level;
    logic          ovf;
    logic [AW-1:0] ram_a_a;
    logic [DW-1:0] ram_d_a;
    logic          ram_w_a;
    logic [AW-1:0] ram_a_b;
    logic [DW-1:0] ram_d_b;
    logic          ram_w_b;
    logic [DW-1:0] ram_q_b;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q[$];

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Dual-port RAM: port A writes, port B reads with one cycle of latency.
    always @(posedge clk) begin
        if (ram_w_a) mem[ram_a_a] <= ram_d_a;
        ram_q_b <= mem[ram_a_b];
    end

    dpram_fifo_ctrl #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .wr_v   (wr_v),
        .wr_d   (wr_d),
        .wr_rdy (wr_rdy),
        .rd_v   (rd_v),
        .rd_d   (rd_d),
        .rd_rdy (rd_rdy),
        .level  (level),
        .ovf    (ovf),
        .ram_a_a(ram_a_a),
        .ram_d_a(ram_d_a),
        .ram_w_a(ram_w_a),
        .ram_a_b(ram_a_b),
        .ram_d_b(ram_d_b),
        .ram_w_b(ram_w_b),
        .ram_q_b(ram_q_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n, input int budget);
        int got = 0;
        rd_rdy = 1'b1;
        for (int c = 0; c < budget && got < n; c++) begin
            #1;
            if (rd_v) begin
                chk("drain_data", rd_d, exp_q.pop_front());
                got++;
            end
            tick();
        end
        rd_rdy = 1'b0;
        chk("drain_count", got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nexp;

        // Reset values
        #1 rst = 1'b0;
        #2;
        chk("rst_rd_v", rd_v, 0);
        chk("rst_rd_d", rd_d, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ram_w_a", ram_w_a, 0);
        chk("rst_ram_w_b", ram_w_b, 0);
        chk("rst_ram_d_b", ram_d_b, 0);
        tick();
        tick();
        #3 rst = 1'b1;
        tick();
        chk("rst_wr_rdy", wr_rdy, 1);

        // Three back-to-back pushes with the consumer stalled
        wr_v = 1'b1; wr_d = 16'h0001; #1;
        chk("t1_ram_w_a", ram_w_a, 1);
        chk("t1_ram_d_a", ram_d_a, 16'h0001);
        chk("t1_rd_v_c0", rd_v, 0);
        exp_q.push_back(16'h0001);
        tick(); wr_d = 16'h0002; #1;
        chk("t1_rd_v_c1", rd_v, 0);
        exp_q.push_back(16'h0002);
        tick(); wr_d = 16'h0003; #1;
        chk("t1_rd_v_c2", rd_v, 0);
        exp_q.push_back(16'h0003);
        tick(); wr_v = 1'b0; #1;
        chk("t1_rd_v_c3", rd_v, 1);
        chk("t1_rd_d_c3", rd_d, 16'h0001);
        chk("t1_level_c3", level, 3);
        chk("t1_ram_w_a_idle", ram_w_a, 0);
        tick(); tick(); #1;
        chk("t1_rd_v_hold", rd_v, 1);
        chk("t1_rd_d_hold", rd_d, 16'h0001);
        chk("t1_level_hold", level, 3);
        drain(3, 12);
        #1;
        chk("t1_rd_v_empty", rd_v, 0);
        chk("t1_level_empty", level, 0);

        // Fill to capacity: 4 in RAM plus 2 in the output buffer
        tick();
        for (int i = 0; i < 7; i++) begin
            wr_v = 1'b1; wr_d = 16'(16'h0010 + i); #1;
            chk("t2_wr_rdy", wr_rdy, (i < 6));
            chk("t2_ovf", ovf, (i == 6));
            chk("t2_ram_w_a", ram_w_a, (i < 6));
            if (i == 6) chk("t2_level_full", level, 6);
            if (i < 6) exp_q.push_back(wr_d);
            tick();
        end
        wr_v = 1'b0; #1;
        chk("t2_ovf_pulse_end", ovf, 0);
        chk("t2_level_held", level, 6);
        chk("t2_head", rd_d, 16'h0010);
        drain(6, 20);
        #1;
        chk("t2_rd_v_empty", rd_v, 0);
        chk("t2_level_empty", level, 0);

        // Continuous streaming with the consumer always ready
        tick();
        nexp = 0;
        for (int c = 0; c < 262; c++) begin
            wr_v = (c < 256); wr_d = 16'(c); rd_rdy = 1'b1; #1;
            if (c < 256) chk("t3_wr_rdy", wr_rdy, 1);
            chk("t3_rd_v", rd_v, (c >= 3 && c < 259));
            if (c >= 3 && c < 259) begin
                chk("t3_rd_d", rd_d, 16'(nexp));
                nexp++;
            end
            chk("t3_level_le3", 32'(level <= 3), 1);
            tick();
        end
        wr_v = 1'b0; rd_rdy = 1'b0; #1;
        chk("t3_count", nexp, 256);
        chk("t3_level_end", level, 0);

        // Consumer ready toggling every cycle against a reference queue
        tick();
        k = 0;
        for (int c = 0; c < 60; c++) begin
            wr_v = (k < 30); wr_d = 16'(16'h0200 + k); rd_rdy = ((c % 2) == 0); #1;
            if (rd_v && rd_rdy) begin
                chk("t4_not_spurious", 32'(exp_q.size() > 0), 1);
                chk("t4_rd_d", rd_d, exp_q.pop_front());
            end
            if (wr_v && wr_rdy) begin
                exp_q.push_back(wr_d);
                k++;
            end
            tick();
        end
        wr_v = 1'b0;
        chk("t4_accepted", k, 30);
        drain(exp_q.size(), 40);
        #1;
        chk("t4_queue_empty", exp_q.size(), 0);
        chk("t4_rd_v_empty", rd_v, 0);
        chk("t4_level_empty", level, 0);

        // Flush while a RAM read is in flight and the head is occupied
        tick();
        for (int i = 0; i < 3; i++) begin
            wr_v = 1'b1; wr_d = 16'(16'h0030 + i);
            tick();
        end
        wr_v = 1'b1; wr_d = 16'h0099; flush = 1'b1; #1;
        chk("t5_level_pre", level, 3);
        chk("t5_rd_v_pre", rd_v, 1);
        chk("t5_ovf_flush", ovf, 0);
        chk("t5_ram_w_a_flush", ram_w_a, 0);
        tick();
        flush = 1'b0; wr_v = 1'b0; #1;
        chk("t5_rd_v_post", rd_v, 0);
        chk("t5_level_post", level, 0);
        chk("t5_wr_rdy_post", wr_rdy, 1);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("t5_no_late_data", rd_v, 0);
        end
        tick();
        wr_v = 1'b1; wr_d = 16'hABCD;
        exp_q.push_back(16'hABCD);
        tick();
        wr_v = 1'b0;
        drain(1, 10);
        #1;
        chk("t5_level_end", level, 0);

        // Asynchronous reset between clock edges mid-stream
        tick();
        for (int i = 0; i < 8; i++) begin
            wr_v = 1'b1; wr_d = 16'(16'h0040 + i);
            tick();
        end
        #1;
        chk("t6_ovf_pre", ovf, 1);
        chk("t6_level_pre", level, 6);
        chk("t6_rd_v_pre", rd_v, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rd_v_rst", rd_v, 0);
        chk("t6_level_rst", level, 0);
        chk("t6_ovf_rst", ovf, 0);
        chk("t6_ram_w_a_rst", ram_w_a, 0);
        wr_v = 1'b0;
        #2 rst = 1'b1;
        tick(); #1;
        chk("t6_level_rel", level, 0);
        chk("t6_rd_v_rel", rd_v, 0);
        chk("t6_wr_rdy_rel", wr_rdy, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("t6_no_stale", rd_v, 0);
        end
        tick();
        wr_v = 1'b1; wr_d = 16'h5A5A;
        exp_q.push_back(16'h5A5A);
        tick();
        wr_v = 1'b0;
        drain(1, 10);
        #1;
        chk("t6_level_end", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
